gpio_int_arbiter: RTL and testbench

// - Round-robin scheduler for GPIO group read-back interrupts. Picks one pending group, pulses its one-hot
//   int_ack into the GPIO group controller, waits for that controller's rd_dv/rd_data frame, and forwards
//   the 48-bit frame to the encoder through a valid/ready handshake.
// - Serialises group service so that only one read-back transaction is ever in flight.

---
 rtl/gpio_arb_pkg.sv | 21 ++
 rtl/gpio_rr_pick.sv | 27 ++
 rtl/gpio_int_arbiter.sv | 142 ++++++++++++++
 tb/tb_gpio_int_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_arb_pkg.sv
// Shared state encoding and default widths for the GPIO interrupt arbiter.
// TOTAL_GPIO falls back to 16 pins (4 groups) when the build does not set it.
`ifndef TOTAL_GPIO
`define TOTAL_GPIO 16
`endif

package gpio_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACK     = 3'd1,
    WAIT_DV = 3'd2,
    PUSH    = 3'd3,
    GUARD   = 3'd4
  } arb_state_t;

  localparam int VALUE_WIDTH  = 48;
  localparam int GRP_ID_WIDTH = 4;
  localparam int CNT_WIDTH    = 16;

endpackage

// File: rtl/gpio_rr_pick.sv
// Wrapped priority search: first set bit of req strictly after ptr, wrapping to ptr itself.

module gpio_rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 4
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] sel,
  output logic           valid
);

  always_comb begin
    int unsigned idx;
    idx   = 0;
    sel   = '0;
    valid = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        sel   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/gpio_int_arbiter.sv
// Round-robin scheduler for GPIO group read-back interrupts; one transaction in flight.
// Define GPIO_ARB_TIMEOUT_EN to bound the WAIT_DV state by TIMEOUT_CLKS cycles.

module gpio_int_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int TOTAL_GRP    = (`TOTAL_GPIO + 3) >> 2,
  parameter int GRP_ID_WIDTH = gpio_arb_pkg::GRP_ID_WIDTH,
  parameter int VALUE_WIDTH  = gpio_arb_pkg::VALUE_WIDTH,
  parameter int GUARD_CLKS   = 4,
  parameter int TIMEOUT_CLKS = 64,
  parameter int CNT_WIDTH    = gpio_arb_pkg::CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arb_en,
  input  logic [TOTAL_GRP-1:0]    interrupt,
  output logic [TOTAL_GRP-1:0]    int_ack,
  input  logic                    rd_dv,
  input  logic [VALUE_WIDTH-1:0]  rd_data,
  output logic                    enc_valid,
  output logic [VALUE_WIDTH-1:0]  enc_data,
  input  logic                    enc_ready,
  output logic                    busy,
  output logic [GRP_ID_WIDTH-1:0] cur_grp,
  output logic [CNT_WIDTH-1:0]    svc_cnt,
  output logic                    timeout_err
);

  // One counter serves both GUARD and WAIT_DV; it restarts on every state change.
  localparam int CNT_MAX = (GUARD_CLKS > TIMEOUT_CLKS) ? GUARD_CLKS : TIMEOUT_CLKS;
  localparam int TW      = $clog2(CNT_MAX + 1);

  arb_state_t              state, state_nxt;
  logic [GRP_ID_WIDTH-1:0] ptr;
  logic [GRP_ID_WIDTH-1:0] pick_sel;
  logic                    pick_valid;
  logic [TOTAL_GRP-1:0]    grp_onehot;
  logic [TOTAL_GRP-1:0]    mask;
  logic [TW-1:0]           cnt;
  logic                    grant, capture, accept;

  assign grp_onehot = TOTAL_GRP'(1) << cur_grp;
  assign mask       = (state == GUARD) ? grp_onehot : '0;
  assign int_ack    = (state == ACK) ? grp_onehot : '0;
  assign enc_valid  = (state == PUSH);
  assign busy       = (state != IDLE);

  gpio_rr_pick #(
    .N   (TOTAL_GRP),
    .IDW (GRP_ID_WIDTH)
  ) u_pick (
    .req   (interrupt & ~mask),
    .ptr   (ptr),
    .sel   (pick_sel),
    .valid (pick_valid)
  );

`ifdef GPIO_ARB_TIMEOUT_EN
  logic to_hit;
  logic timeout_q;

  always_ff @(posedge clk) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= to_hit;
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
`ifdef GPIO_ARB_TIMEOUT_EN
    to_hit    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (arb_en && pick_valid) begin
          grant     = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (rd_dv) begin
          capture   = 1'b1;
          state_nxt = PUSH;
        end else begin
          state_nxt = WAIT_DV;
        end
      end
      WAIT_DV: begin
        if (rd_dv) begin
          capture   = 1'b1;
          state_nxt = PUSH;
        end
`ifdef GPIO_ARB_TIMEOUT_EN
        else if (cnt == TW'(TIMEOUT_CLKS - 1)) begin
          to_hit    = 1'b1;
          state_nxt = GUARD;
        end
`endif
      end
      PUSH: begin
        if (enc_ready) begin
          accept    = 1'b1;
          state_nxt = GUARD;
        end
      end
      GUARD: begin
        if (cnt == TW'(GUARD_CLKS - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= GRP_ID_WIDTH'(TOTAL_GRP - 1);
      cur_grp  <= '0;
      enc_data <= '0;
      svc_cnt  <= '0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        ptr     <= pick_sel;
        cur_grp <= pick_sel;
      end
      if (capture) enc_data <= rd_data;
      if (accept && (svc_cnt != '1)) svc_cnt <= svc_cnt + 1'b1;
      if (state_nxt != state)                        cnt <= '0;
      else if ((state == WAIT_DV) || (state == GUARD)) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_gpio_int_arbiter.sv
// Self-checking bench for gpio_int_arbiter: directed scenarios plus randomized round-robin traffic.

module tb_gpio_int_arbiter;

  localparam int GUARD = 4;

  logic        clk = 1'b0;
  logic        rst, arb_en, rd_dv, enc_ready;
  logic [3:0]  interrupt, int_ack;
  logic [47:0] rd_data, enc_data;
  logic        enc_valid, busy, timeout_err;
  logic [3:0]  cur_grp;
  logic [15:0] svc_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr;
  int m_svc;

  gpio_int_arbiter #(
    .TOTAL_GRP    (4),
    .GRP_ID_WIDTH (4),
    .VALUE_WIDTH  (48),
    .GUARD_CLKS   (GUARD),
    .TIMEOUT_CLKS (64),
    .CNT_WIDTH    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arb_en      (arb_en),
    .interrupt   (interrupt),
    .int_ack     (int_ack),
    .rd_dv       (rd_dv),
    .rd_data     (rd_data),
    .enc_valid   (enc_valid),
    .enc_data    (enc_data),
    .enc_ready   (enc_ready),
    .busy        (busy),
    .cur_grp     (cur_grp),
    .svc_cnt     (svc_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Round-robin rule: first pending group after the last one served, wrapping.
  function automatic int pick(input logic [3:0] req, input int p);
    for (int k = 1; k <= 4; k++) if (req[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plays the group controller and the encoder for one transaction; returns observations.
  task automatic serve(input logic [47:0] data, input int dv_delay, input int stall,
                       output logic [3:0] ack, output int ack_wait, output int ack_pulses,
                       output logic got_valid, output logic [47:0] got_data,
                       output logic hold_ok, output logic valid_after);
    int n = 0;
    ack = '0; ack_wait = 0; ack_pulses = 0; got_valid = 1'b0; got_data = '0;
    hold_ok = 1'b1; valid_after = 1'b1;
    while (int_ack == '0 && n < 40) begin step(); n++; end
    ack_wait = n;
    ack = int_ack;
    if (ack == '0) return;
    ack_pulses = 1;
    enc_ready = (stall == 0);
    for (int i = 0; i < dv_delay; i++) begin
      step();
      if (int_ack != '0) ack_pulses++;
    end
    rd_dv = 1'b1; rd_data = data;
    step();
    if (int_ack != '0) ack_pulses++;
    rd_dv = 1'b0; rd_data = 48'({$urandom, $urandom});
    got_valid = enc_valid; got_data = enc_data;
    for (int i = 0; i < stall; i++) begin
      step();
      if (!enc_valid || enc_data !== got_data || int_ack != '0) hold_ok = 1'b0;
    end
    enc_ready = 1'b1;
    step();
    valid_after = enc_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; arb_en = 1'b1; rd_dv = 1'b0; enc_ready = 1'b0;
    interrupt = '0; rd_data = '0;
    repeat (3) step();
    n_cmp++;
    if ({int_ack, enc_valid, busy, cur_grp, svc_cnt, timeout_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ack=%b v=%b busy=%b grp=%0d svc=%0d to=%b, required all 0",
               int_ack, enc_valid, busy, cur_grp, svc_cnt, timeout_err);
    end
    n_cmp++;
    if (enc_data !== '0) begin
      n_err++; $display("FAIL reset_enc_data: got %h required 0", enc_data);
    end
    rst = 1'b0; m_ptr = 3; m_svc = 0;
  endtask

  task automatic test_idle();
    logic bad = 1'b0;
    interrupt = 4'b0000;
    repeat (8) begin
      step();
      if (int_ack !== '0 || busy !== 1'b0 || svc_cnt !== '0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++; $display("FAIL idle_quiet: got activity with no interrupt, required none");
    end
  endtask

  task automatic test_basic();
    logic [3:0] ack; int w, pulses; logic gv, hold, va; logic [47:0] gd; int e;
    interrupt = 4'b0101;
    e = pick(4'b0101, m_ptr);
    serve(48'h008F000000AA, 3, 0, ack, w, pulses, gv, gd, hold, va);
    n_cmp++;
    if (ack !== 4'(1 << e)) begin n_err++; $display("FAIL basic_ack1: got %b required %b", ack, 4'(1 << e)); end
    n_cmp++;
    if (w !== 1) begin n_err++; $display("FAIL grant_latency: got %0d required 1", w); end
    n_cmp++;
    if (gv !== 1'b1 || gd !== 48'h008F000000AA) begin
      n_err++; $display("FAIL basic_data: got v=%b %h required v=1 008f000000aa", gv, gd);
    end
    n_cmp++;
    if (pulses !== 1) begin n_err++; $display("FAIL ack_one_cycle: got %0d cycles required 1", pulses); end
    m_ptr = e; m_svc++;
    interrupt = 4'b0100;
    e = pick(4'b0100, m_ptr);
    serve(48'h123456789ABC, 0, 0, ack, w, pulses, gv, gd, hold, va);
    n_cmp++;
    if (ack !== 4'(1 << e)) begin n_err++; $display("FAIL basic_ack2: got %b required %b", ack, 4'(1 << e)); end
    m_ptr = e; m_svc++;
    n_cmp++;
    if (svc_cnt !== 16'(m_svc)) begin n_err++; $display("FAIL basic_svc: got %0d required %0d", svc_cnt, m_svc); end
    interrupt = '0;
  endtask

  task automatic test_guard();
    logic [3:0] ack; int w, pulses; logic gv, hold, va; logic [47:0] gd; int e;
    logic bad = 1'b0;
    interrupt = 4'b0010;
    e = pick(4'b0010, m_ptr);
    serve(48'h0000_1111_2222, 1, 0, ack, w, pulses, gv, gd, hold, va);
    m_ptr = e; m_svc++;
    for (int s = 0; s <= GUARD; s++) begin
      if (int_ack !== '0 || busy !== (s < GUARD)) bad = 1'b1;
      step();
    end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL guard_mask: got early re-grant or wrong busy, required %0d masked clks", GUARD); end
    n_cmp++;
    if (int_ack !== 4'b0010) begin n_err++; $display("FAIL guard_regrant: got %b required 0010", int_ack); end
    serve(48'h0000_3333_4444, 2, 0, ack, w, pulses, gv, gd, hold, va);
    interrupt = '0;
    m_svc++;
    n_cmp++;
    if (svc_cnt !== 16'(m_svc)) begin n_err++; $display("FAIL guard_svc: got %0d required %0d", svc_cnt, m_svc); end
  endtask

  task automatic test_stall();
    logic [3:0] ack; int w, pulses; logic gv, hold, va; logic [47:0] gd; int e;
    interrupt = 4'b1000;
    e = pick(4'b1000, m_ptr);
    serve(48'hDEAD_BEEF_0123, 2, 10, ack, w, pulses, gv, gd, hold, va);
    interrupt = '0;
    n_cmp++;
    if (ack !== 4'(1 << e)) begin n_err++; $display("FAIL stall_ack: got %b required %b", ack, 4'(1 << e)); end
    n_cmp++;
    if (hold !== 1'b1 || gd !== 48'hDEAD_BEEF_0123) begin
      n_err++; $display("FAIL stall_hold: got hold=%b data=%h required hold=1 deadbeef0123", hold, gd);
    end
    n_cmp++;
    if (va !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL stall_accept: got valid=%b busy=%b required 0 1", va, busy);
    end
    m_ptr = e; m_svc++;
    n_cmp++;
    if (svc_cnt !== 16'(m_svc)) begin n_err++; $display("FAIL stall_svc: got %0d required %0d", svc_cnt, m_svc); end
  endtask

  task automatic test_arb_en();
    logic [3:0] ack; int w, pulses; logic gv, hold, va; logic [47:0] gd; int e;
    logic bad = 1'b0;
    arb_en = 1'b0;
    interrupt = 4'b0001;
    for (int s = 0; s < 10; s++) begin
      rd_dv = (s == 7); rd_data = 48'hFFFF_0000_FFFF;
      step();
      if (int_ack !== '0 || enc_valid !== 1'b0) bad = 1'b1;
    end
    rd_dv = 1'b0;
    n_cmp++;
    if (bad || busy !== 1'b0) begin n_err++; $display("FAIL arb_en_off: got grant or stray enc_valid, required none"); end
    arb_en = 1'b1;
    e = pick(4'b0001, m_ptr);
    serve(48'h0102_0304_0506, 0, 1, ack, w, pulses, gv, gd, hold, va);
    interrupt = '0;
    n_cmp++;
    if (ack !== 4'(1 << e) || w !== 1) begin
      n_err++; $display("FAIL arb_en_on: got %b after %0d required %b after 1", ack, w, 4'(1 << e));
    end
    m_ptr = e; m_svc++;
  endtask

`ifdef GPIO_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] ack; int w, pulses; logic gv, hold, va; logic [47:0] gd; int e;
    int n = 0; int k = 0; logic bad = 1'b0;
    interrupt = 4'b0010;
    e = pick(4'b0010, m_ptr);
    while (int_ack == '0 && n < 40) begin step(); n++; end
    n_cmp++;
    if (int_ack !== 4'(1 << e)) begin n_err++; $display("FAIL to_ack: got %b required %b", int_ack, 4'(1 << e)); end
    m_ptr = e;
    interrupt = 4'b0110;
    step();
    while (!timeout_err && k < 100) begin
      if (enc_valid) bad = 1'b1;
      step(); k++;
    end
    n_cmp++;
    if (k !== 64 || bad) begin n_err++; $display("FAIL to_pulse_time: got %0d clks valid_seen=%b required 64 0", k, bad); end
    step();
    n_cmp++;
    if (timeout_err !== 1'b0 || svc_cnt !== 16'(m_svc)) begin
      n_err++; $display("FAIL to_after: got to=%b svc=%0d required 0 %0d", timeout_err, svc_cnt, m_svc);
    end
    e = pick(4'b0110, m_ptr);
    serve(48'h0A0B_0C0D_0E0F, 1, 0, ack, w, pulses, gv, gd, hold, va);
    interrupt = '0;
    n_cmp++;
    if (ack !== 4'(1 << e)) begin n_err++; $display("FAIL to_next_grp: got %b required %b", ack, 4'(1 << e)); end
    m_ptr = e; m_svc++;
  endtask
`endif

  task automatic test_random();
    logic [3:0] ack; int w, pulses; logic gv, hold, va; logic [47:0] gd; int e;
    logic [3:0] pending = '0;
    logic [47:0] data;
    for (int i = 0; i < 25; i++) begin
      if (pending == '0) pending = 4'($urandom_range(1, 15));
      interrupt = pending;
      e = pick(pending, m_ptr);
      data = 48'({$urandom, $urandom});
      serve(data, $urandom_range(0, 5), $urandom_range(0, 3), ack, w, pulses, gv, gd, hold, va);
      m_ptr = e; m_svc++;
      n_cmp++;
      if (ack !== 4'(1 << e) || cur_grp !== 4'(e)) begin
        n_err++; $display("FAIL rand_grant[%0d]: got %b grp=%0d required %b grp=%0d", i, ack, cur_grp, 4'(1 << e), e);
      end
      n_cmp++;
      if (gv !== 1'b1 || gd !== data || hold !== 1'b1 || va !== 1'b0 || pulses !== 1) begin
        n_err++; $display("FAIL rand_xfer[%0d]: got v=%b %h hold=%b after=%b pulses=%0d required 1 %h 1 0 1",
                          i, gv, gd, hold, va, pulses, data);
      end
      n_cmp++;
      if (svc_cnt !== 16'(m_svc)) begin n_err++; $display("FAIL rand_svc[%0d]: got %0d required %0d", i, svc_cnt, m_svc); end
      if (i > 0) begin
        n_cmp++;
        if (w !== GUARD + 1) begin n_err++; $display("FAIL rand_gap[%0d]: got %0d clks required %0d", i, w, GUARD + 1); end
      end
      pending = (pending & ~ack) | (4'($urandom) & 4'($urandom));
      interrupt = pending;
    end
    interrupt = '0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    interrupt = '0;
    repeat (8) step();
    interrupt = 4'b0100;
    while (int_ack == '0 && n < 40) begin step(); n++; end
    interrupt = '0;
    rd_dv = 1'b1; rd_data = 48'hA5A5_5A5A_A5A5; enc_ready = 1'b0;
    step();
    rd_dv = 1'b0;
    repeat (2) step();
    n_cmp++;
    if (enc_valid !== 1'b1) begin n_err++; $display("FAIL rmid_push: got enc_valid=%b required 1", enc_valid); end
    rst = 1'b1;
    step();
    n_cmp++;
    if (enc_valid !== 1'b0 || busy !== 1'b0 || svc_cnt !== '0 || int_ack !== '0) begin
      n_err++; $display("FAIL rmid_abort: got v=%b busy=%b svc=%0d ack=%b required 0 0 0 0", enc_valid, busy, svc_cnt, int_ack);
    end
    rst = 1'b0; m_ptr = 3; m_svc = 0;
    interrupt = 4'b1111;
    step();
    n_cmp++;
    if (int_ack !== 4'(1 << pick(4'b1111, m_ptr))) begin
      n_err++; $display("FAIL rmid_ptr: got %b required %b", int_ack, 4'(1 << pick(4'b1111, m_ptr)));
    end
    interrupt = '0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_guard();
    test_stall();
    test_arb_en();
`ifdef GPIO_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
